// File: rtl/fifo_pkg.sv
// Shared helpers for the synchronous FIFO.
// Pointer width and power-of-two check.
package fifo_pkg;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port, one async read port.
// Contents are intentionally not reset.
module fifo_mem #(
    parameter int DEPTH = 128,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy, threshold
// and sticky error flags.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int FIFO_SIZE     = 128,
    parameter int LOGIC_SIZE    = 32,
    parameter int AFULL_THRESH  = FIFO_SIZE - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_wr,
    input  logic [LOGIC_SIZE-1:0]           i_wdata,
    output logic                            o_wfull,
    input  logic                            i_rr,
    output logic [LOGIC_SIZE-1:0]           o_rdata,
    output logic                            o_rempty,
    output logic [ptr_w(FIFO_SIZE)-1:0]     o_count,
    output logic                            o_almost_full,
    output logic                            o_almost_empty,
    output logic                            o_overflow,
    output logic                            o_underflow
);

    localparam int AW = $clog2(FIFO_SIZE);
    localparam int PW = ptr_w(FIFO_SIZE);
    localparam logic [PW-1:0] AF_T = PW'(AFULL_THRESH);
    localparam logic [PW-1:0] AE_T = PW'(AEMPTY_THRESH);

    if (!is_pow2(FIFO_SIZE) || FIFO_SIZE < 2) begin : g_bad_size
        $error("sync_fifo: FIFO_SIZE must be a power of two >= 2");
    end
    if (LOGIC_SIZE < 1) begin : g_bad_width
        $error("sync_fifo: LOGIC_SIZE must be >= 1");
    end

    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic                  wr_ok;
    logic                  rd_ok;
    logic [LOGIC_SIZE-1:0] mem_rdata;

    // Flags derive only from registered pointers, never from requests.
    assign o_rempty = (wptr == rptr);
    assign o_wfull  = (wptr[AW-1:0] == rptr[AW-1:0]) &&
                      (wptr[PW-1] != rptr[PW-1]);
    assign o_count  = wptr - rptr;

    assign o_almost_full  = (o_count >= AF_T);
    assign o_almost_empty = (o_count <= AE_T);

    assign wr_ok = i_wr && !o_wfull;
    assign rd_ok = i_rr && !o_rempty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr        <= '0;
            rptr        <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_ok) begin
                rptr <= rptr + 1'b1;
            end
            if (i_wr && o_wfull) begin
                o_overflow <= 1'b1;
            end
            if (i_rr && o_rempty) begin
                o_underflow <= 1'b1;
            end
        end
    end

    fifo_mem #(
        .DEPTH (FIFO_SIZE),
        .WIDTH (LOGIC_SIZE),
        .AW    (AW)
    ) u_mem (
        .clk   (i_clk),
        .we    (wr_ok),
        .waddr (wptr[AW-1:0]),
        .wdata (i_wdata),
        .raddr (rptr[AW-1:0]),
        .rdata (mem_rdata)
    );

    assign o_rdata = o_rempty ? '0 : mem_rdata;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo.
// Reference queue model tracks data, count and sticky flags.
module tb_sync_fifo;

    localparam int D  = 128;
    localparam int W  = 32;
    localparam int PW = $clog2(D) + 1;

    logic          clk;
    logic          rst_n;
    logic          wr;
    logic [W-1:0]  wdata;
    logic          wfull;
    logic          rr;
    logic [W-1:0]  rdata;
    logic          rempty;
    logic [PW-1:0] count;
    logic          afull;
    logic          aempty;
    logic          ovf;
    logic          unf;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] q[$];
    int           cnt;
    logic         ovf_m;
    logic         unf_m;

    sync_fifo #(
        .FIFO_SIZE     (D),
        .LOGIC_SIZE    (W),
        .AFULL_THRESH  (D - 4),
        .AEMPTY_THRESH (4)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_wr           (wr),
        .i_wdata        (wdata),
        .o_wfull        (wfull),
        .i_rr           (rr),
        .o_rdata        (rdata),
        .o_rempty       (rempty),
        .o_count        (count),
        .o_almost_full  (afull),
        .o_almost_empty (aempty),
        .o_overflow     (ovf),
        .o_underflow    (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic chk_flags();
        chk("count", 64'(count), 64'(cnt));
        chk("empty", 64'(rempty), 64'(cnt == 0));
        chk("full", 64'(wfull), 64'(cnt == D));
        chk("afull", 64'(afull), 64'(cnt >= D - 4));
        chk("aempty", 64'(aempty), 64'(cnt <= 4));
        chk("ovf", 64'(ovf), 64'(ovf_m));
        chk("unf", 64'(unf), 64'(unf_m));
    endtask

    // Starts #1 after a rising edge, ends #1 after the next one.
    task automatic cyc(input logic w, input logic r,
                       input logic [W-1:0] d);
        logic wa;
        logic ra;
        wr    = w;
        rr    = r;
        wdata = d;
        wa = w && (cnt < D);
        ra = r && (cnt != 0);
        #3;
        if (ra) chk("rdata", 64'(rdata), 64'(q[0]));
        else if (cnt == 0) chk("rdata0", 64'(rdata), 64'd0);
        @(posedge clk);
        #1;
        if (w && cnt == D) ovf_m = 1'b1;
        if (r && cnt == 0) unf_m = 1'b1;
        if (ra) void'(q.pop_front());
        if (wa) q.push_back(d);
        cnt = cnt + int'(wa) - int'(ra);
        wr = 1'b0;
        rr = 1'b0;
        chk_flags();
    endtask

    task automatic model_reset();
        q.delete();
        cnt   = 0;
        ovf_m = 1'b0;
        unf_m = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        wr    = 1'b0;
        rr    = 1'b0;
        wdata = '0;
        model_reset();

        // reset held for two clocks
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", 64'(rempty), 64'd1);
        chk("rst_full", 64'(wfull), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_aempty", 64'(aempty), 64'd1);
        chk("rst_afull", 64'(afull), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_unf", 64'(unf), 64'd0);
        rst_n = 1'b1;

        // fill with distinct words, then one rejected write
        for (int i = 0; i < D; i++) begin
            cyc(1'b1, 1'b0,
                {i[7:0], 24'($urandom_range(0, 24'hFFFFFF))});
        end
        chk("fill_full", 64'(wfull), 64'd1);
        chk("fill_afull", 64'(afull), 64'd1);
        cyc(1'b1, 1'b0, 32'hDEAD_BEEF);
        chk("ovf_count", 64'(count), 64'(D));
        chk("ovf_set", 64'(ovf), 64'd1);

        // drain, then one rejected read
        for (int i = 0; i < D; i++) cyc(1'b0, 1'b1, '0);
        chk("drain_empty", 64'(rempty), 64'd1);
        cyc(1'b0, 1'b1, '0);
        chk("unf_set", 64'(unf), 64'd1);
        chk("unf_count", 64'(count), 64'd0);

        // streaming at occupancy 1
        cyc(1'b1, 1'b0, 32'h1234_5678);
        for (int i = 0; i < 1000; i++) begin
            cyc(1'b1, 1'b1, $urandom);
            chk("stream_cnt", 64'(count), 64'd1);
        end

        // rate mismatch across many wraps
        for (int c = 0; c < 3000; c++) begin
            cyc((c % 3) != 2, (c % 2) == 0, $urandom);
        end
        n = 0;
        while (cnt != 0 && n < 2 * D) begin
            cyc(1'b0, 1'b1, '0);
            n++;
        end
        chk("drain_done", 64'(cnt == 0), 64'd1);

        // mid-operation asynchronous reset
        for (int i = 0; i < 50; i++) cyc(1'b1, 1'b0, $urandom);
        chk("pre_rst_cnt", 64'(count), 64'd50);
        chk("pre_rst_ovf", 64'(ovf), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_empty", 64'(rempty), 64'd1);
        chk("mid_count", 64'(count), 64'd0);
        chk("mid_ovf", 64'(ovf), 64'd0);
        chk("mid_unf", 64'(unf), 64'd0);
        chk("mid_rdata", 64'(rdata), 64'd0);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        chk_flags();
        cyc(1'b1, 1'b0, 32'hA5A5_0001);
        cyc(1'b0, 1'b1, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
